pc_stack_ctrl: RTL and testbench
================================

Name: pc_stack_ctrl

Overview:
Parametrised next-generation program counter for the lab microprocessor datapath. It adds relative branching and subroutine call/return to the existing load/increment behaviour, using a hardware LIFO return-address stack. It sits between the control unit (command strobes) and instruction memory (PC address). The board harness shows PC on HEX1/HEX0 and SP on a spare display.

Parameters:
ADDR_W, 8, width of PC, ADDR and OFFSET in bits (4..16)
STACK_DEPTH, 4, number of return-address entries (power of 2 not required, 1..16)
RESET_ADDR, 0, value loaded into PC on reset (ADDR_W bits)

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  asynchronous, active-high; clears all state immediately
LOAD_PC  input  1  absolute jump: PC <= ADDR
INCR_PC  input  1  sequential step: PC <= PC+1
BRANCH_PC  input  1  relative jump: PC <= PC + signed OFFSET
CALL  input  1  push PC+1, then PC <= ADDR
RET  input  1  PC <= top of stack, pop
ADDR  input  ADDR_W  absolute target for LOAD_PC/CALL
OFFSET  input  ADDR_W  two's-complement displacement for BRANCH_PC
PC  output  ADDR_W  current program counter (registered)
SP  output  $clog2(STACK_DEPTH+1)  number of valid stack entries
STACK_FULL  output  1  SP == STACK_DEPTH (combinational from SP)
STACK_EMPTY  output  1  SP == 0 (combinational from SP)
STACK_ERR  output  1  sticky overflow/underflow flag

Behaviour:
- Reset (async, any time, including mid-call): PC=RESET_ADDR, SP=0, STACK_ERR=0, stack contents don't-care. On release, first edge acts normally.
- One operation per clk edge; fixed priority when several strobes are high: RET > CALL > LOAD_PC > BRANCH_PC > INCR_PC > hold.
- Latency: PC and SP update on the same edge as the command; the new value is visible after that edge. No multi-cycle operations.
- Arithmetic: all PC math is modulo 2^ADDR_W. PC=max + INCR wraps to 0. BRANCH sign-extends OFFSET within ADDR_W and wraps both ways. The CALL return address is PC+1, also wrapped.
- CALL, not full: stack[SP] <= PC+1, SP <= SP+1, PC <= ADDR.
- CALL, full (overflow): no push, PC unchanged, SP unchanged, STACK_ERR <= 1.
- RET, not empty: PC <= stack[SP-1], SP <= SP-1.
- RET, empty (underflow): PC unchanged, SP unchanged, STACK_ERR <= 1.
- STACK_ERR stays 1 until reset; a set flag does not block further operations.
- A RET+CALL collision resolves to RET only; the CALL is dropped with no error.
- Hold (no strobe): all state is retained.
- No combinational path from inputs to PC or SP.

Decomposition:
- Shared package pc_pkg:
  - typedef enum pc_op_e {OP_HOLD, OP_INCR, OP_BRANCH, OP_LOAD, OP_CALL, OP_RET}.
  - Function decode_op(ret, call, load, branch, incr) implementing the priority order.
  - Constant PC_STACK_DEPTH_MAX = 16.
- Sub-module ret_stack: a parametrised LIFO (DATA_W, DEPTH) with push/pop/top/count/full/empty and async active-high reset of count. pc_stack_ctrl owns the PC register, op decode and error flag.

Test Plan:
1. Reset then INCR_PC for 3 clocks -> PC 0,1,2,3; SP=0, STACK_EMPTY=1, STACK_ERR=0.
2. Wrap: LOAD_PC ADDR=8'hFF, then INCR_PC -> PC=8'h00. Then BRANCH_PC OFFSET=8'hFE (-2) -> PC=8'hFE. Then BRANCH_PC OFFSET=8'h05 -> PC=8'h03.
3. Nested calls: PC=8'h10, CALL ADDR=8'h40, then CALL ADDR=8'h80 -> PC=8'h80, SP=2. Then RET -> PC=8'h41, SP=1. Then RET -> PC=8'h11, SP=0.
4. Overflow: 4 CALLs fill the stack (STACK_FULL=1). A 5th CALL ADDR=8'hAA -> PC unchanged, SP=4, STACK_ERR=1. Four RETs then return the correct addresses in LIFO order.
5. Underflow and priority: RET with SP=0 -> PC held, STACK_ERR=1. RET and CALL together with SP=1 -> only the pop occurs, SP=0. LOAD_PC and INCR_PC together -> PC=ADDR.
6. Async reset mid-sequence: after 2 CALLs, pulse reset between edges -> PC=RESET_ADDR, SP=0 and STACK_ERR=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared types and helpers for the program counter block.
// Operation encoding plus the strobe priority decoder.
package pc_pkg;

   localparam int PC_STACK_DEPTH_MAX = 16;

   typedef enum logic [2:0] {
      OP_HOLD,
      OP_INCR,
      OP_BRANCH,
      OP_LOAD,
      OP_CALL,
      OP_RET
   } pc_op_e;

   function automatic pc_op_e decode_op(
      input logic ret,
      input logic call,
      input logic load,
      input logic branch,
      input logic incr
   );
      pc_op_e op;
      if (ret)         op = OP_RET;
      else if (call)   op = OP_CALL;
      else if (load)   op = OP_LOAD;
      else if (branch) op = OP_BRANCH;
      else if (incr)   op = OP_INCR;
      else             op = OP_HOLD;
      return op;
   endfunction

endpackage

// File: rtl/ret_stack.sv
// Parametrised LIFO holding subroutine return addresses.
// Only the entry count is reset; entry contents are don't-care.
module ret_stack
   import pc_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  logic                       pop,
   input  logic [DATA_W-1:0]          din,
   output logic [DATA_W-1:0]          top,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       full,
   output logic                       empty
);

   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [CNT_W-1:0]  cnt_q;
   logic [CNT_W-1:0]  cnt_m1;
   logic [IDX_W-1:0]  wr_idx;
   logic [IDX_W-1:0]  rd_idx;
   logic              do_push;
   logic              do_pop;

   assign cnt_m1  = cnt_q - CNT_W'(1);
   assign wr_idx  = cnt_q[IDX_W-1:0];
   assign rd_idx  = cnt_m1[IDX_W-1:0];
   assign full    = (cnt_q == CNT_W'(DEPTH));
   assign empty   = (cnt_q == '0);
   // Pop wins over push so a collision never corrupts the count.
   assign do_pop  = pop && !empty;
   assign do_push = push && !pop && !full;
   assign top     = mem[rd_idx];
   assign count   = cnt_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else if (do_pop) begin
         cnt_q <= cnt_m1;
      end else if (do_push) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_idx] <= din;
      end
   end

endmodule

// File: rtl/pc_stack_ctrl.sv
// Program counter with load, increment, relative branch and
// call/return through a hardware return-address stack.
module pc_stack_ctrl
   import pc_pkg::*;
#(
   parameter int                ADDR_W      = 8,
   parameter int                STACK_DEPTH = 4,
   parameter logic [ADDR_W-1:0] RESET_ADDR  = '0
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             LOAD_PC,
   input  logic                             INCR_PC,
   input  logic                             BRANCH_PC,
   input  logic                             CALL,
   input  logic                             RET,
   input  logic [ADDR_W-1:0]                ADDR,
   input  logic [ADDR_W-1:0]                OFFSET,
   output logic [ADDR_W-1:0]                PC,
   output logic [$clog2(STACK_DEPTH+1)-1:0] SP,
   output logic                             STACK_FULL,
   output logic                             STACK_EMPTY,
   output logic                             STACK_ERR
);

   pc_op_e            op;
   logic [ADDR_W-1:0] pc_q;
   logic [ADDR_W-1:0] pc_d;
   logic [ADDR_W-1:0] pc_inc;
   logic [ADDR_W-1:0] top;
   logic              push;
   logic              pop;
   logic              err_q;
   logic              err_set;
   logic              full;
   logic              empty;

   assign op     = decode_op(RET, CALL, LOAD_PC, BRANCH_PC, INCR_PC);
   assign pc_inc = pc_q + ADDR_W'(1);

   // Same-width add wraps both ways, so OFFSET needs no explicit extension.
   always_comb begin
      pc_d    = pc_q;
      push    = 1'b0;
      pop     = 1'b0;
      err_set = 1'b0;
      unique case (op)
         OP_RET: begin
            if (!empty) begin
               pc_d = top;
               pop  = 1'b1;
            end else begin
               err_set = 1'b1;
            end
         end
         OP_CALL: begin
            if (!full) begin
               pc_d = ADDR;
               push = 1'b1;
            end else begin
               err_set = 1'b1;
            end
         end
         OP_LOAD:   pc_d = ADDR;
         OP_BRANCH: pc_d = pc_q + OFFSET;
         OP_INCR:   pc_d = pc_inc;
         default:   pc_d = pc_q;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_q  <= RESET_ADDR;
         err_q <= 1'b0;
      end else begin
         pc_q  <= pc_d;
         err_q <= err_q | err_set;
      end
   end

   ret_stack #(
      .DATA_W (ADDR_W),
      .DEPTH  (STACK_DEPTH)
   ) u_stack (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .din   (pc_inc),
      .top   (top),
      .count (SP),
      .full  (full),
      .empty (empty)
   );

   assign PC          = pc_q;
   assign STACK_FULL  = full;
   assign STACK_EMPTY = empty;
   assign STACK_ERR   = err_q;

endmodule

// File: tb/tb_pc_stack_ctrl.sv
// Directed bench for pc_stack_ctrl with default parameters.
// Outputs are sampled 1 time unit after each rising edge.
module tb_pc_stack_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       LOAD_PC, INCR_PC, BRANCH_PC, CALL, RET;
   logic [7:0] ADDR, OFFSET;
   logic [7:0] PC;
   logic [2:0] SP;
   logic       STACK_FULL, STACK_EMPTY, STACK_ERR;

   int n_chk  = 0;
   int n_fail = 0;

   pc_stack_ctrl #(
      .ADDR_W      (8),
      .STACK_DEPTH (4),
      .RESET_ADDR  (8'h00)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .LOAD_PC     (LOAD_PC),
      .INCR_PC     (INCR_PC),
      .BRANCH_PC   (BRANCH_PC),
      .CALL        (CALL),
      .RET         (RET),
      .ADDR        (ADDR),
      .OFFSET      (OFFSET),
      .PC          (PC),
      .SP          (SP),
      .STACK_FULL  (STACK_FULL),
      .STACK_EMPTY (STACK_EMPTY),
      .STACK_ERR   (STACK_ERR)
   );

   always #5 clk = ~clk;

   task automatic idle();
      {LOAD_PC, INCR_PC, BRANCH_PC, CALL, RET} = 5'b0;
      ADDR   = 8'h00;
      OFFSET = 8'h00;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      idle();
   endtask

   task automatic do_reset();
      @(posedge clk);
      #2;
      reset = 1'b1;
      #4;
      reset = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      idle();
      #12;
      n_chk++;
      if ({PC, SP, STACK_EMPTY, STACK_FULL, STACK_ERR} !== {8'h00, 3'd0, 3'b100}) begin
         n_fail++;
         $display("FAIL reset_state: pc=%h sp=%0d e=%b f=%b err=%b want 00 0 1 0 0",
                  PC, SP, STACK_EMPTY, STACK_FULL, STACK_ERR);
      end
      reset = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_incr();
      logic [7:0] exp_pc;
      for (int i = 1; i <= 3; i++) begin
         INCR_PC = 1'b1;
         step();
         exp_pc = 8'(i);
         n_chk++;
         if ({PC, SP, STACK_EMPTY, STACK_ERR} !== {exp_pc, 3'd0, 2'b10}) begin
            n_fail++;
            $display("FAIL incr_%0d: pc=%h sp=%0d e=%b err=%b want %h 0 1 0",
                     i, PC, SP, STACK_EMPTY, STACK_ERR, exp_pc);
         end
      end
   endtask

   task automatic test_wrap();
      logic [7:0] offs [3];
      logic [7:0] exps [3];
      LOAD_PC = 1'b1;
      ADDR    = 8'hFF;
      step();
      n_chk++;
      if (PC !== 8'hFF) begin
         n_fail++;
         $display("FAIL load_ff: pc=%h want ff", PC);
      end
      INCR_PC = 1'b1;
      step();
      n_chk++;
      if (PC !== 8'h00) begin
         n_fail++;
         $display("FAIL incr_wrap: pc=%h want 00", PC);
      end
      offs = '{8'hFE, 8'h05, 8'h80};
      exps = '{8'hFE, 8'h03, 8'h83};
      for (int i = 0; i < 3; i++) begin
         BRANCH_PC = 1'b1;
         OFFSET    = offs[i];
         step();
         n_chk++;
         if (PC !== exps[i]) begin
            n_fail++;
            $display("FAIL branch_%0d: pc=%h want %h", i, PC, exps[i]);
         end
      end
   endtask

   task automatic test_nested();
      LOAD_PC = 1'b1;
      ADDR    = 8'h10;
      step();
      CALL = 1'b1;
      ADDR = 8'h40;
      step();
      n_chk++;
      if ({PC, SP} !== {8'h40, 3'd1}) begin
         n_fail++;
         $display("FAIL call1: pc=%h sp=%0d want 40 1", PC, SP);
      end
      CALL = 1'b1;
      ADDR = 8'h80;
      step();
      n_chk++;
      if ({PC, SP} !== {8'h80, 3'd2}) begin
         n_fail++;
         $display("FAIL call2: pc=%h sp=%0d want 80 2", PC, SP);
      end
      RET = 1'b1;
      step();
      n_chk++;
      if ({PC, SP} !== {8'h41, 3'd1}) begin
         n_fail++;
         $display("FAIL ret1: pc=%h sp=%0d want 41 1", PC, SP);
      end
      RET = 1'b1;
      step();
      n_chk++;
      if ({PC, SP, STACK_EMPTY, STACK_ERR} !== {8'h11, 3'd0, 2'b10}) begin
         n_fail++;
         $display("FAIL ret2: pc=%h sp=%0d e=%b err=%b want 11 0 1 0",
                  PC, SP, STACK_EMPTY, STACK_ERR);
      end
   endtask

   task automatic test_overflow();
      logic [7:0] tgt  [4];
      logic [7:0] rets [4];
      tgt  = '{8'h30, 8'h40, 8'h50, 8'h60};
      rets = '{8'h51, 8'h41, 8'h31, 8'h21};
      LOAD_PC = 1'b1;
      ADDR    = 8'h20;
      step();
      for (int i = 0; i < 4; i++) begin
         CALL = 1'b1;
         ADDR = tgt[i];
         step();
      end
      n_chk++;
      if ({PC, SP, STACK_FULL, STACK_EMPTY, STACK_ERR} !== {8'h60, 3'd4, 3'b100}) begin
         n_fail++;
         $display("FAIL fill: pc=%h sp=%0d f=%b e=%b err=%b want 60 4 1 0 0",
                  PC, SP, STACK_FULL, STACK_EMPTY, STACK_ERR);
      end
      CALL = 1'b1;
      ADDR = 8'hAA;
      step();
      n_chk++;
      if ({PC, SP, STACK_FULL, STACK_ERR} !== {8'h60, 3'd4, 2'b11}) begin
         n_fail++;
         $display("FAIL overflow: pc=%h sp=%0d f=%b err=%b want 60 4 1 1",
                  PC, SP, STACK_FULL, STACK_ERR);
      end
      for (int i = 0; i < 4; i++) begin
         RET = 1'b1;
         step();
         n_chk++;
         if ({PC, SP, STACK_ERR} !== {rets[i], 3'(3 - i), 1'b1}) begin
            n_fail++;
            $display("FAIL lifo_%0d: pc=%h sp=%0d err=%b want %h %0d 1",
                     i, PC, SP, STACK_ERR, rets[i], 3 - i);
         end
      end
      n_chk++;
      if ({STACK_EMPTY, STACK_FULL} !== 2'b10) begin
         n_fail++;
         $display("FAIL drained: e=%b f=%b want 1 0", STACK_EMPTY, STACK_FULL);
      end
   endtask

   task automatic test_underflow_priority();
      do_reset();
      n_chk++;
      if (STACK_ERR !== 1'b0) begin
         n_fail++;
         $display("FAIL err_cleared: err=%b want 0", STACK_ERR);
      end
      LOAD_PC = 1'b1;
      ADDR    = 8'h07;
      step();
      RET = 1'b1;
      step();
      n_chk++;
      if ({PC, SP, STACK_ERR} !== {8'h07, 3'd0, 1'b1}) begin
         n_fail++;
         $display("FAIL underflow: pc=%h sp=%0d err=%b want 07 0 1", PC, SP, STACK_ERR);
      end
      CALL = 1'b1;
      ADDR = 8'h33;
      step();
      n_chk++;
      if ({PC, SP} !== {8'h33, 3'd1}) begin
         n_fail++;
         $display("FAIL call_after_err: pc=%h sp=%0d want 33 1", PC, SP);
      end
      RET  = 1'b1;
      CALL = 1'b1;
      ADDR = 8'h99;
      step();
      n_chk++;
      if ({PC, SP, STACK_ERR} !== {8'h08, 3'd0, 1'b1}) begin
         n_fail++;
         $display("FAIL ret_call: pc=%h sp=%0d err=%b want 08 0 1", PC, SP, STACK_ERR);
      end
      LOAD_PC = 1'b1;
      INCR_PC = 1'b1;
      ADDR    = 8'h5C;
      step();
      n_chk++;
      if (PC !== 8'h5C) begin
         n_fail++;
         $display("FAIL load_incr: pc=%h want 5c", PC);
      end
      step();
      n_chk++;
      if ({PC, SP} !== {8'h5C, 3'd0}) begin
         n_fail++;
         $display("FAIL hold: pc=%h sp=%0d want 5c 0", PC, SP);
      end
      BRANCH_PC = 1'b1;
      INCR_PC   = 1'b1;
      OFFSET    = 8'h10;
      step();
      n_chk++;
      if (PC !== 8'h6C) begin
         n_fail++;
         $display("FAIL branch_incr: pc=%h want 6c", PC);
      end
      LOAD_PC   = 1'b1;
      BRANCH_PC = 1'b1;
      ADDR      = 8'h21;
      OFFSET    = 8'h04;
      step();
      n_chk++;
      if (PC !== 8'h21) begin
         n_fail++;
         $display("FAIL load_branch: pc=%h want 21", PC);
      end
   endtask

   task automatic test_async_reset();
      RET = 1'b1;
      step();
      LOAD_PC = 1'b1;
      ADDR    = 8'h12;
      step();
      CALL = 1'b1;
      ADDR = 8'h20;
      step();
      CALL = 1'b1;
      ADDR = 8'h30;
      step();
      n_chk++;
      if ({PC, SP, STACK_ERR} !== {8'h30, 3'd2, 1'b1}) begin
         n_fail++;
         $display("FAIL pre_reset: pc=%h sp=%0d err=%b want 30 2 1", PC, SP, STACK_ERR);
      end
      #2;
      reset = 1'b1;
      #1;
      n_chk++;
      if ({PC, SP, STACK_EMPTY, STACK_ERR} !== {8'h00, 3'd0, 2'b10}) begin
         n_fail++;
         $display("FAIL async_reset: pc=%h sp=%0d e=%b err=%b want 00 0 1 0",
                  PC, SP, STACK_EMPTY, STACK_ERR);
      end
      #2;
      reset = 1'b0;
      INCR_PC = 1'b1;
      step();
      n_chk++;
      if ({PC, SP} !== {8'h01, 3'd0}) begin
         n_fail++;
         $display("FAIL post_reset_incr: pc=%h sp=%0d want 01 0", PC, SP);
      end
   endtask

   initial begin
      test_reset();
      test_incr();
      test_wrap();
      test_nested();
      test_overflow();
      test_underflow_priority();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
